// File: rtl/intr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intr_pkg : shared constants and state type for the MSI-X interrupt block   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package intr_pkg;

  localparam int TICK_NS = 256;
  localparam int ITR_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2
  } vec_state_e;

  localparam int CAUSE_TXDW   = 0;
  localparam int CAUSE_LSC    = 2;
  localparam int CAUSE_RXDMT0 = 4;
  localparam int CAUSE_RXT0   = 7;

endpackage
`default_nettype wire

// File: rtl/intr_vec_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intr_vec_timer : per-vector request FSM with ITR holdoff counter           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module intr_vec_timer #(
  parameter int ITR_W = intr_pkg::ITR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             pend_i,
  input  logic             tick_i,
  input  logic             grant_i,
  input  logic [ITR_W-1:0] itr_i,
  output logic             arm_o
);
  import intr_pkg::*;

  vec_state_e       state_q, state_d;
  logic [ITR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ARM ignores en_i and pend_i so an issued request is never retracted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (en_i && pend_i) state_d = ARM;
      ARM: begin
        if (grant_i) begin
          cnt_d   = '0;
          state_d = (itr_i == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == itr_i) state_d = IDLE;
        else if (tick_i)    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arm_o = (state_q == ARM);

endmodule
`default_nettype wire

// File: rtl/intr_msix_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intr_msix_ctrl : ICR/IMS cause latching, vector mapping, ITR throttling     |
// | and round-robin MSI-X message request generation. Rev 1.0                  |
// +----------------------------------------------------------------------------+
module intr_msix_ctrl #(
  parameter int NUM_SRC       = 32,
  parameter int NUM_VEC       = 4,
  parameter int VEC_W         = 2,
  parameter int CLK_PERIOD_NS = 8,
  parameter int ITR_W         = intr_pkg::ITR_W,
  parameter bit AUTO_CLEAR    = 1'b1,
  parameter int IDX_W         = $clog2(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_req_i,
  input  logic [NUM_SRC-1:0] icr_i,
  input  logic               icr_set_i,
  input  logic               icr_get_i,
  output logic [NUM_SRC-1:0] icr_o,
  input  logic [NUM_SRC-1:0] ics_i,
  input  logic               ics_set_i,
  input  logic [NUM_SRC-1:0] ims_i,
  input  logic               ims_set_i,
  input  logic [NUM_SRC-1:0] imc_i,
  input  logic               imc_set_i,
  input  logic [IDX_W-1:0]   ivar_idx_i,
  input  logic [VEC_W-1:0]   ivar_vec_i,
  input  logic               ivar_set_i,
  input  logic [VEC_W-1:0]   itr_vec_i,
  input  logic [ITR_W-1:0]   itr_i,
  input  logic               itr_set_i,
  input  logic               msix_en_i,
  output logic               intr_o,
  output logic               msg_valid_o,
  output logic [VEC_W-1:0]   msg_vec_o,
  input  logic               msg_ready_i
);
  import intr_pkg::*;

  localparam int c_TICK_CYCLES = TICK_NS / CLK_PERIOD_NS;
  localparam int c_TICK_W      = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;

  logic [NUM_SRC-1:0]  icr_q, icr_d, ims_q, ims_d;
  logic [VEC_W-1:0]    ivar_q [NUM_SRC];
  logic [ITR_W-1:0]    itr_q  [NUM_VEC];
  logic [c_TICK_W-1:0] pre_q;
  logic                intr_q;
  logic                msg_valid_q, msg_valid_d;
  logic [VEC_W-1:0]    msg_vec_q, msg_vec_d, ptr_q, ptr_d;

  logic                w_tick, w_hs, w_found;
  logic [NUM_SRC-1:0]  w_act, w_base;
  logic [NUM_SRC-1:0]  w_vmask [NUM_VEC];
  logic [NUM_VEC-1:0]  w_pend, w_arm, w_cand;
  logic [VEC_W-1:0]    w_start, w_sel;

  assign w_tick = (pre_q == c_TICK_W'(c_TICK_CYCLES - 1));
  assign w_hs   = msg_valid_q && msg_ready_i;
  assign w_act  = icr_q & ims_q;

  always_comb begin
    for (int v = 0; v < NUM_VEC; v++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        w_vmask[v][s] = (ivar_q[s] == VEC_W'(v));
      end
    end
  end

  // Register writes resolve first; auto-clear and new cause pulses apply on top
  always_comb begin
    if (icr_get_i)      w_base = '0;
    else if (icr_set_i) w_base = icr_q & ~icr_i;
    else if (ics_set_i) w_base = icr_q | ics_i;
    else                w_base = icr_q;
    icr_d = w_base;
    if (AUTO_CLEAR && w_hs) icr_d = w_base & ~w_vmask[msg_vec_q];
    icr_d = icr_d | src_req_i;
  end

  always_comb begin
    if (ims_set_i)      ims_d = ims_q | ims_i;
    else if (imc_set_i) ims_d = ims_q & ~imc_i;
    else                ims_d = ims_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      icr_q  <= '0;
      ims_q  <= '0;
      pre_q  <= '0;
      intr_q <= 1'b0;
      for (int s = 0; s < NUM_SRC; s++) ivar_q[s] <= '0;
      for (int v = 0; v < NUM_VEC; v++) itr_q[v] <= '0;
    end else begin
      icr_q  <= icr_d;
      ims_q  <= ims_d;
      pre_q  <= w_tick ? '0 : pre_q + 1'b1;
      intr_q <= !msix_en_i && (|w_act);
      if (ivar_set_i && (int'(ivar_vec_i) < NUM_VEC)) ivar_q[ivar_idx_i] <= ivar_vec_i;
      if (itr_set_i && (int'(itr_vec_i) < NUM_VEC))   itr_q[itr_vec_i]   <= itr_i;
    end
  end

  for (genvar v = 0; v < NUM_VEC; v++) begin : g_vec
    assign w_pend[v] = |(w_act & w_vmask[v]);

    intr_vec_timer #(
      .ITR_W (ITR_W)
    ) u_timer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (msix_en_i),
      .pend_i  (w_pend[v]),
      .tick_i  (w_tick),
      .grant_i (w_hs && (msg_vec_q == VEC_W'(v))),
      .itr_i   (itr_q[v]),
      .arm_o   (w_arm[v])
    );
  end

  // The granted vector still reads ARM on its handshake cycle, so mask it out
  always_comb begin
    w_cand  = w_arm;
    w_start = ptr_q;
    if (w_hs) begin
      w_cand[msg_vec_q] = 1'b0;
      w_start           = VEC_W'((int'(msg_vec_q) + 1) % NUM_VEC);
    end
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (!w_found && w_cand[(int'(w_start) + i) % NUM_VEC]) begin
        w_found = 1'b1;
        w_sel   = VEC_W'((int'(w_start) + i) % NUM_VEC);
      end
    end
    msg_valid_d = msg_valid_q;
    msg_vec_d   = msg_vec_q;
    ptr_d       = ptr_q;
    if (!msg_valid_q || w_hs) begin
      msg_valid_d = w_found;
      if (w_found) msg_vec_d = w_sel;
    end
    if (w_hs) ptr_d = w_start;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      msg_valid_q <= 1'b0;
      msg_vec_q   <= '0;
      ptr_q       <= '0;
    end else begin
      msg_valid_q <= msg_valid_d;
      msg_vec_q   <= msg_vec_d;
      ptr_q       <= ptr_d;
    end
  end

  assign icr_o       = icr_q;
  assign intr_o      = intr_q;
  assign msg_valid_o = msg_valid_q;
  assign msg_vec_o   = msg_vec_q;

endmodule
`default_nettype wire
